// File: rtl/conv5x5_mac.sv
// conv5x5_mac: 5x5 window formation plus 3-stage signed MAC pipeline.
// Define CONV5X5_RELU_EN to clamp negative results to zero.
module conv5x5_mac #(
   parameter int DW    = 9,
   parameter int WW    = 8,
   parameter int OW    = 22,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   input  logic                 frame_start,
   input  logic signed [DW-1:0] taps0,
   input  logic signed [DW-1:0] taps1,
   input  logic signed [DW-1:0] taps2,
   input  logic signed [DW-1:0] taps3,
   input  logic signed [DW-1:0] taps4,
   input  logic                 w_load,
   input  logic [4:0]           w_addr,
   input  logic signed [WW-1:0] w_data,
   output logic                 out_valid,
   output logic signed [OW-1:0] out_data
);

   localparam int PW = DW + WW;
   localparam int RW = PW + 3;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int HW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [HW-1:0] ROW_LAST = HW'(IMG_H - 1);

   logic [CW-1:0] col;
   logic [CW-1:0] cur_col;
   logic [HW-1:0] row;
   logic [HW-1:0] cur_row;
   logic          pos_ok;

   logic signed [DW-1:0] tap_row [5];
   logic signed [DW-1:0] win [5][5];
   logic                 win_vld;

   logic signed [WW-1:0] w [25];

   logic signed [PW-1:0] prod_c [5][5];
   logic signed [PW-1:0] prod [5][5];
   logic                 v1;

   logic signed [RW-1:0] rs_c [5];
   logic signed [RW-1:0] rs [5];
   logic                 v2;

   logic signed [OW-1:0] tot_c;
   logic signed [OW-1:0] res_c;

   // frame_start overrides the running position for the pixel it tags
   always_comb begin
      cur_col = frame_start ? '0 : col;
      cur_row = frame_start ? '0 : row;
      pos_ok  = (cur_col >= CW'(4)) && (cur_row >= HW'(4));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + HW'(1);
         end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
         end
      end
   end

   // taps0 is the newest line, so it feeds the bottom window row
   always_comb begin
      tap_row[0] = taps4;
      tap_row[1] = taps3;
      tap_row[2] = taps2;
      tap_row[3] = taps1;
      tap_row[4] = taps0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               win[r][c] <= '0;
            end
         end
         win_vld <= 1'b0;
      end else begin
         win_vld <= in_valid && pos_ok;
         if (in_valid) begin
            for (int r = 0; r < 5; r++) begin
               for (int c = 0; c < 4; c++) begin
                  win[r][c] <= win[r][c+1];
               end
               win[r][4] <= tap_row[r];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 25; i++) begin
            w[i] <= '0;
         end
      end else if (w_load && (w_addr < 5'd25)) begin
         w[w_addr] <= w_data;
      end
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            prod_c[r][c] = PW'(win[r][c]) * PW'(w[r*5+c]);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               prod[r][c] <= '0;
            end
         end
         v1 <= 1'b0;
      end else begin
         prod <= prod_c;
         v1   <= win_vld;
      end
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         rs_c[r] = '0;
         for (int c = 0; c < 5; c++) begin
            rs_c[r] = rs_c[r] + RW'(prod[r][c]);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < 5; r++) begin
            rs[r] <= '0;
         end
         v2 <= 1'b0;
      end else begin
         rs <= rs_c;
         v2 <= v1;
      end
   end

   always_comb begin
      tot_c = '0;
      for (int r = 0; r < 5; r++) begin
         tot_c = tot_c + OW'(rs[r]);
      end
`ifdef CONV5X5_RELU_EN
      res_c = tot_c[OW-1] ? '0 : tot_c;
`else
      res_c = tot_c;
`endif
   end

   // out_data keeps the last result while no new one arrives
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            out_data <= res_c;
         end
      end
   end

endmodule

// File: tb/tb_conv5x5_mac.sv
// tb_conv5x5_mac: directed vectors and corner sequences for conv5x5_mac.
// Expected results come from per-pixel values and a position model.
module tb_conv5x5_mac;

   localparam int DW    = 9;
   localparam int WW    = 8;
   localparam int OW    = 22;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 in_valid;
   logic                 frame_start;
   logic signed [DW-1:0] taps0;
   logic signed [DW-1:0] taps1;
   logic signed [DW-1:0] taps2;
   logic signed [DW-1:0] taps3;
   logic signed [DW-1:0] taps4;
   logic                 w_load;
   logic [4:0]           w_addr;
   logic signed [WW-1:0] w_data;
   logic                 out_valid;
   logic signed [OW-1:0] out_data;

   conv5x5_mac #(
      .DW(DW), .WW(WW), .OW(OW), .IMG_W(IMG_W), .IMG_H(IMG_H)
   ) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid),
      .frame_start(frame_start),
      .taps0(taps0), .taps1(taps1), .taps2(taps2),
      .taps3(taps3), .taps4(taps4),
      .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
      .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   longint oq_v[$];
   int     oq_t[$];
   longint eq_v[$];
   int     eq_t[$];

   always @(posedge clk) begin
      #1;
      if (out_valid === 1'b1) begin
         oq_v.push_back(longint'(out_data));
         oq_t.push_back(cyc);
      end
   end

   int n_run  = 0;
   int n_fail = 0;
   int mc = 0;
   int mr = 0;

   typedef struct {
      int     w;
      int     t;
      longint e;
   } vec_t;

   vec_t tbl [6];

   function automatic longint relu(input longint v);
`ifdef CONV5X5_RELU_EN
      return (v < 0) ? 64'sd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input longint act,
                        input longint exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_all(input string name);
      int n;
      check({name, " count"}, longint'(oq_v.size()),
            longint'(eq_v.size()));
      n = (oq_v.size() < eq_v.size()) ? oq_v.size() : eq_v.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s val[%0d]", name, i), oq_v[i], eq_v[i]);
         check($sformatf("%s cyc[%0d]", name, i),
               longint'(oq_t[i]), longint'(eq_t[i]));
      end
      oq_v.delete();
      oq_t.delete();
      eq_v.delete();
      eq_t.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid    = 1'b0;
         frame_start = 1'b0;
         w_load      = 1'b0;
      end
   endtask

   task automatic px(input bit fs, input int t0, input int t1,
                     input int t2, input int t3, input int t4,
                     input longint ev, input bit wl = 1'b0,
                     input int wa = 0, input int wd = 0);
      @(negedge clk);
      in_valid    = 1'b1;
      frame_start = fs;
      taps0  = DW'(t0);
      taps1  = DW'(t1);
      taps2  = DW'(t2);
      taps3  = DW'(t3);
      taps4  = DW'(t4);
      w_load = wl;
      w_addr = 5'(wa);
      w_data = WW'(wd);
      if (fs) begin
         mc = 0;
         mr = 0;
      end
      if (mc >= 4 && mr >= 4) begin
         eq_v.push_back(relu(ev));
         eq_t.push_back(cyc + 4);
      end
      mc++;
      if (mc == IMG_W) begin
         mc = 0;
         mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end
   endtask

   task automatic load_w(input int a, input int v);
      @(negedge clk);
      in_valid    = 1'b0;
      frame_start = 1'b0;
      w_load      = 1'b1;
      w_addr      = 5'(a);
      w_data      = WW'(v);
   endtask

   task automatic load_all(input int v);
      for (int i = 0; i < 25; i++) load_w(i, v);
      idle(1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn        = 1'b0;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      w_load      = 1'b0;
      mc = 0;
      mr = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn        = 1'b0;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      taps0 = '0; taps1 = '0; taps2 = '0; taps3 = '0; taps4 = '0;
      w_load = 1'b0;
      w_addr = '0;
      w_data = '0;
      repeat (3) @(negedge clk);
      check("reset out_valid", longint'(out_valid), 0);
      check("reset out_data", longint'(out_data), 0);
      rstn = 1'b1;

      tbl[0] = '{1, 1, 25};
      tbl[1] = '{-128, -256, 819200};
      tbl[2] = '{127, -256, -812800};
      tbl[3] = '{0, 7, 0};
      tbl[4] = '{2, 3, 150};
      tbl[5] = '{-1, 5, -125};

      for (int k = 0; k < 6; k++) begin
         do_reset();
         load_all(tbl[k].w);
         for (int i = 0; i < IMG_W * IMG_H; i++) begin
            px(i == 0, tbl[k].t, tbl[k].t, tbl[k].t, tbl[k].t,
               tbl[k].t, tbl[k].e);
         end
         idle(6);
         check($sformatf("vec%0d idle valid", k), longint'(out_valid), 0);
         check($sformatf("vec%0d hold data", k), longint'(out_data),
               relu(tbl[k].e));
         compare_all($sformatf("vec%0d", k));
      end

      // centre tap only; two frames with in_valid gaps, second unflagged
      do_reset();
      load_w(12, 1);
      idle(1);
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
               if (f == 0 && r == 5 && c >= 10 && c < 14) idle(1);
               px(f == 0 && r == 0 && c == 0, c + r, c + r - 1,
                  c + r - 2, c + r - 3, c + r - 4,
                  longint'((c - 2) + (r - 2)));
            end
         end
      end
      idle(6);
      compare_all("ramp");

      // w[0] rewrite while streaming; address 31 must be ignored
      do_reset();
      load_all(1);
      for (int i = 0; i < 5 * IMG_W; i++) begin
         px(i == 0, 1, 1, 1, 1, 1, (i >= 122) ? 26 : 25,
            (i == 118) || (i == 122), (i == 122) ? 0 : 31,
            (i == 122) ? 2 : 5);
      end
      idle(6);
      compare_all("wchg");

      // reset with results in flight
      do_reset();
      load_all(1);
      for (int i = 0; i < 4 * IMG_W + 10; i++) begin
         px(i == 0, 1, 1, 1, 1, 1, 25);
      end
      @(negedge clk);
      check("pre-rst valid high", longint'(out_valid), 1);
      rstn        = 1'b0;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      #1;
      check("rst out_valid", longint'(out_valid), 0);
      check("rst out_data", longint'(out_data), 0);
      while (eq_t.size() > 0 && eq_t[$] > cyc) begin
         void'(eq_t.pop_back());
         void'(eq_v.pop_back());
      end
      compare_all("pre-rst");
      mc = 0;
      mr = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      load_all(1);
      for (int i = 0; i < 5 * IMG_W; i++) begin
         px(1'b0, 1, 1, 1, 1, 1, 25);
      end
      idle(6);
      compare_all("post-rst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/conv5x5_mac.md
# conv5x5_mac

Pipelined 5x5 convolution engine directly downstream of the CNN line-buffer stage (`CNN_windows_1`). Each cycle it accepts one 5-row pixel column (taps0x..taps4x) and shifts it into a 5x5 window register. For every window position fully inside the image, it multiplies the window by a loadable signed 5x5 kernel and emits one accumulated result. It replaces the testbench-side 4-deep tap delay chains with synthesizable window formation plus the MAC.

## Interface
- `DW`, 9: pixel width, signed.
- `WW`, 8: weight width, signed.
- `OW`, 22: output width; must be ≥ DW+WW+5.
- `IMG_W`, 28: pixels per line.
- `IMG_H`, 28: lines per frame.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  the taps are valid this cycle; the pixel is accepted at the edge.
- `frame_start`  in  1  qualified by `in_valid`; marks the accepted pixel as image position (0,0).
- `taps0`..`taps4`  in  DW each  one pixel column; `taps0` is the newest line (window row 4), `taps4` the oldest line (window row 0).
- `w_load`  in  1  weight write strobe.
- `w_addr`  in  5  weight index, row-major: r*5+c, valid range 0..24.
- `w_data`  in  WW  weight value, signed.
- `out_valid`  out  1  one-cycle pulse per result.
- `out_data`  out  OW  signed convolution result.

## Operation
- **Window shift.** On each accepted pixel, `win[r][c] <= win[r][c+1]` for c = 0..3, and `win[r][4] <=` the tap for row r. With no accepted pixel the window holds.
- **Position counters.** `col` and `row` track the position of the accepted pixel.
  - `col` counts 0..IMG_W-1, wraps to 0 and increments `row`.
  - `row` counts 0..IMG_H-1; it wraps to 0 after pixel (IMG_W-1, IMG_H-1).
  - `frame_start` forces the accepted pixel to (0,0); the next pixel is (1,0).
- **Window validity.** The window is valid when the accepted pixel has col ≥ 4 and row ≥ 4. A full frame therefore yields (IMG_W-4)*(IMG_H-4) results.
- **Pipeline.** The pipeline advances every cycle; a valid bit travels with each stage.
  - S1: 25 registered products `win[r][c]*w[r*5+c]`, each DW+WW bits signed.
  - S2: five row sums, each DW+WW+3 bits.
  - S3: final sum, sign-extended to OW bits, registered into `out_data`/`out_valid`.
- **Arithmetic.** Full-precision two's complement; no rounding. With OW ≥ DW+WW+5 the sum cannot overflow.
- **Weights.** 25 registers. When `w_load`=1, `w[w_addr] <= w_data` at the edge; `w_addr` > 24 is ignored.
  - S1 uses the register contents present before its edge, so a write at edge N affects products formed at edge N+1 and later.
  - Writes during streaming are legal; the kernel is not double-buffered.
- **Gaps.** `in_valid` gaps produce gaps in `out_valid`; results are never merged or dropped.

## Timing
- **Latency.** A pixel accepted at edge N completes the window. `out_valid` is high in the cycle following edge N+3 (3 cycles), with matching `out_data`.
- **Throughput.** One result per cycle.
- **Reset values.** All of the following are 0:
  - window registers, weights, `col`, `row`, and all pipeline data and valid bits;
  - outputs: `out_valid`=0, `out_data`=0.
- **Reset mid-operation.** Results in flight are discarded and not emitted. After release, the first accepted pixel is (0,0) even without `frame_start`, and weights must be reloaded.
- **Simultaneous `frame_start` and pipeline contents.** Results already in S1–S3 still emit; only the counters restart.
- **Simultaneous `w_load` and `in_valid`.** Both take effect at the same edge, with no conflict.
- **Between results.** `out_data` holds its last value while `out_valid`=0.

## Configuration
- `CONV5X5_RELU_EN` defined:
  - S3 outputs max(sum, 0); negative sums produce `out_data`=0 with `out_valid` still 1.
  - No added latency.
- Undefined: the signed sum passes unchanged.

## Test plan
- All weights 1; every tap 1; one 28x28 frame with `frame_start` on the first pixel -> exactly 576 `out_valid` pulses, each `out_data`=25.
- Only w[12]=1, others 0; ramp input with pixel value = col+row (taps per row consistent) -> each result equals the centre pixel (col-2)+(row-2) of its window, appearing 3 cycles after the completing pixel.
- All weights -128; all taps -256 -> `out_data`=819200 (no overflow). All weights 127 with taps -256 -> -812800 without the macro, 0 with `CONV5X5_RELU_EN`.
- `in_valid` toggled 1,0,1,0 mid-line -> `out_valid` mirrors the pattern delayed 3 cycles; results are identical to a gapless run.
- Rewrite w[0] from 1 to 2 at edge N while streaming -> windows completed at edge N or later use 2; windows completed earlier use 1. `w_addr`=31 write -> no weight changes.
- Assert `rstn`=0 mid-frame with results in flight -> `out_valid`/`out_data` go to 0 immediately. After release, no `out_valid` until 4 rows+4 pixels of a new frame are accepted.
